regression_sample_ctrl: RTL
===========================

// Module: regression_sample_ctrl
// PURPOSE
// - Upstream control stage for the linear-regression accumulate/divide datapath.
// - Accepts a stream of (x,y) samples over a valid/ready handshake and forwards them to the datapath.
// - Sequences the datapath's init/load strobes and counts N_SAMPLES accepted samples.
// - Waits for the combinational divide to settle, then flags the b0/b1 results as valid.
// PARAMETERS
// - N_SAMPLES      150   samples per regression run; must match the datapath divisor
// - DW             20    sample width (x, y)
// - CW             9     sample counter width; requires 2^CW > N_SAMPLES
// - SETTLE_CYCLES  4     wait cycles after the last accumulate before done; must be >= 1
// - TIMEOUT_CYCLES 1024  idle limit in WAIT_S; used only with REG_CTRL_TIMEOUT_EN
// PORTS
// - clk           in   1   clock, rising edge
// - rst           in   1   reset, asynchronous, active-high
// - start         in   1   begin a run; sampled in IDLE/DONE only
// - abort         in   1   synchronous return to IDLE from any state
// - in_valid      in   1   sample valid
// - in_ready      out  1   sample ready; high only in WAIT_S
// - in_x          in   DW  sample x
// - in_y          in   DW  sample y
// - x_out, y_out  out  DW  to datapath x/y; combinational pass of in_x/in_y
// - ldx, ldy      out  1   = in_valid & in_ready (same cycle)
// - initsumx/y/xx/xy out 1 each; all four identical
// - ldsumx/y/xx/xy   out 1 each; all four identical
// - en            out  1   datapath enable; = busy
// - count         out  CW  samples accumulated in the current run
// - busy          out  1   high in INIT, WAIT_S, ACC, SETTLE
// - done          out  1   one-cycle pulse on entry to DONE
// - result_valid  out  1   b0/b1 valid; held until next start, abort or rst
// - err_timeout   out  1   one-cycle pulse on timeout
// BEHAVIOUR
// - Reset: state=IDLE; count=0; all strobes, done, result_valid and err_timeout = 0.
// - Reset mid-run discards the run; the datapath is cleared by the same rst.
// - IDLE/DONE: start=1 -> INIT; result_valid cleared on the same edge.
// - INIT: one cycle with initsum*=1 and count<=0 -> WAIT_S.
// - WAIT_S: in_ready=1; on in_valid=1, ldx/ldy=1 and the datapath registers the sample -> ACC.
// - WAIT_S with in_valid=0: stay in WAIT_S.
// - ACC: one cycle with ldsum*=1 and count<=count+1.
// - ACC exit: if count==N_SAMPLES-1 -> SETTLE, otherwise -> WAIT_S.
// - Throughput: at most 1 sample per 2 cycles; in_ready=0 in ACC acts as backpressure.
// - SETTLE: down-counter loaded with SETTLE_CYCLES-1; at 0 -> DONE.
// - DONE: done=1 for one cycle, result_valid<=1, count holds N_SAMPLES -> IDLE.
// - Start during INIT, WAIT_S, ACC or SETTLE is ignored.
// - abort=1 -> IDLE on the next edge; count<=0, result_valid<=0, no done pulse.
// - abort has priority over start and over a same-cycle handshake; ldx/ldy are forced to 0 while abort=1.
// - Strobes are mutually exclusive: at most one of the init/ldx/ldsum groups is high in any cycle.
// - Arithmetic: count is unsigned CW bits and never wraps within a run.
// CONFIGURATION
// - REG_CTRL_TIMEOUT_EN defined:
//   - an idle counter runs in WAIT_S while in_valid=0 and resets on any handshake;
//   - at TIMEOUT_CYCLES: err_timeout pulses, state -> IDLE, count<=0, result_valid stays 0.
// - REG_CTRL_TIMEOUT_EN undefined:
//   - no idle counter; err_timeout tied to 0; WAIT_S waits indefinitely.
// TESTING
// - rst high 3 cycles -> every output 0; in_ready=0.
// - start, then 150 samples x=k, y=2k+5 with in_valid always high:
//   - ready toggles 1/0;
//   - done pulses 1+300+4 cycles after INIT;
//   - count=150; result_valid=1; datapath b1=2048, b0=5.
// - Random in_valid gaps (0-7 cycles): ldx only when in_valid&in_ready; count increments once per accepted sample; same done and count results.
// - abort at sample 77 -> IDLE next cycle, count=0, no done; start again completes 150 samples.
// - start pulsed during WAIT_S and SETTLE -> no effect; single done per run.
// - REG_CTRL_TIMEOUT_EN with TIMEOUT_CYCLES=16, in_valid low 16 cycles at sample 10 -> err_timeout pulse, IDLE; macro undefined: stays WAIT_S.

Source files
------------

// File: rtl/regression_sample_ctrl.sv
// Control stage for the linear-regression datapath: accepts N_SAMPLES (x,y) samples,
// sequences init/load strobes and flags b0/b1 valid. Optional idle timeout: REG_CTRL_TIMEOUT_EN.
module regression_sample_ctrl #(
    parameter int N_SAMPLES      = 150,
    parameter int DW             = 20,
    parameter int CW             = 9,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    input  logic [DW-1:0] in_y,
    output logic [DW-1:0] x_out,
    output logic [DW-1:0] y_out,
    output logic          ldx,
    output logic          ldy,
    output logic          initsumx,
    output logic          initsumy,
    output logic          initsumxx,
    output logic          initsumxy,
    output logic          ldsumx,
    output logic          ldsumy,
    output logic          ldsumxx,
    output logic          ldsumxy,
    output logic          en,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          result_valid,
    output logic          err_timeout,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        WAIT_S = 3'd2,
        ACC    = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LAST_IDX    = CW'(N_SAMPLES - 1);

    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || (2 ** CW) <= N_SAMPLES) begin : g_bad_params
        $error("regression_sample_ctrl: inconsistent parameters");
    end

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          init_r;
    logic          ldsum_r;
    logic          hs;

    // Handshake: a sample transfers in the cycle where in_valid and in_ready are both
    // high; in_ready is registered and only high in WAIT_S, abort suppresses the transfer.
    assign hs = in_valid & in_ready & ~abort;

    assign x_out     = in_x;
    assign y_out     = in_y;
    assign ldx       = hs;
    assign ldy       = hs;
    assign initsumx  = init_r;
    assign initsumy  = init_r;
    assign initsumxx = init_r;
    assign initsumxy = init_r;
    assign ldsumx    = ldsum_r;
    assign ldsumy    = ldsum_r;
    assign ldsumxx   = ldsum_r;
    assign ldsumxy   = ldsum_r;
    assign en        = busy;
    assign state_dbg = state;

`ifdef REG_CTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            settle_cnt   <= '0;
            in_ready     <= 1'b0;
            init_r       <= 1'b0;
            ldsum_r      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
`ifdef REG_CTRL_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            // Pulse-type outputs default low every cycle.
            done        <= 1'b0;
            err_timeout <= 1'b0;
            init_r      <= 1'b0;
            ldsum_r     <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                count        <= '0;
                settle_cnt   <= '0;
                in_ready     <= 1'b0;
                busy         <= 1'b0;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state        <= INIT;
                            init_r       <= 1'b1;
                            busy         <= 1'b1;
                            result_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    INIT: begin
                        count    <= '0;
                        state    <= WAIT_S;
                        in_ready <= 1'b1;
`ifdef REG_CTRL_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                    WAIT_S: begin
                        if (hs) begin
                            state    <= ACC;
                            in_ready <= 1'b0;
                            ldsum_r  <= 1'b1;
`ifdef REG_CTRL_TIMEOUT_EN
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LIMIT) begin
                            state       <= IDLE;
                            in_ready    <= 1'b0;
                            busy        <= 1'b0;
                            count       <= '0;
                            err_timeout <= 1'b1;
                            idle_cnt    <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + TW'(1);
`endif
                        end
                    end
                    ACC: begin
                        count <= count + CW'(1);
                        if (count == LAST_IDX) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            state    <= WAIT_S;
                            in_ready <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        // Gives the combinational divide time to settle before flagging results.
                        if (settle_cnt == '0) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            result_valid <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - SW'(1);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
